posit_normalize_arbiter: RTL and testbench

Shares one posit normalize/round unit among `NUM_REQ` requesters, such as the accumulator lanes of a PE row. Each requester presents a denormalized posit (sign, zero, NaR, scale, fraction, guard/round/sticky) over a valid/ready handshake. A round-robin arbiter grants one requester per cycle. The granted operand passes through a 2-stage registered pipeline around the shared normalizer. The posit word comes out with the source index and a valid/ready handshake.

---
 rtl/posit_normalize_arbiter_pkg.sv | 48 ++++
 rtl/posit_normalize_arbiter_normalizer.sv | 86 ++++++++
 rtl/posit_normalize_arbiter_rr_arbiter.sv | 39 +++
 rtl/posit_normalize_arbiter.sv | 112 +++++++++++
 tb/tb_posit_normalize_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/posit_normalize_arbiter_pkg.sv
// Shared types and width helpers for the denormalized-posit (pd) operand format.
// Operand field order, MSB first: sign, zero, NaR, scale, fraction, guard, round, sticky.
package posit_normalize_arbiter_pkg;

    typedef enum logic [1:0] {
        RZERO    = 2'd0,
        RNTE     = 2'd1,
        RPLUSINF = 2'd2,
        RMININF  = 2'd3
    } rounding_e;

    typedef enum logic {
        NORMAL = 1'b0,
        WIDE   = 1'b1
    } pd_type_e;

    // Signed scale width: covers +/-(n-2)*2^es plus the exponent field, with a sign bit.
    function automatic int get_scale_width(input int n, input int es, input pd_type_e t);
        int w;
        w = $clog2((n - 1) << es) + 1;
        return (t == WIDE) ? w + 1 : w;
    endfunction

    function automatic int get_fraction_width(input int n, input int es, input pd_type_e t);
        return (t == WIDE) ? 2 * n : n - 3 - es;
    endfunction

    function automatic int pd_width(input int n, input int es, input pd_type_e t);
        return 6 + get_scale_width(n, es, t) + get_fraction_width(n, es, t);
    endfunction

    localparam int DEF_POSIT_WIDTH = 32;
    localparam int DEF_POSIT_ES    = 2;
    localparam int DEF_SCALE_W     = get_scale_width(DEF_POSIT_WIDTH, DEF_POSIT_ES, NORMAL);
    localparam int DEF_FRAC_W      = get_fraction_width(DEF_POSIT_WIDTH, DEF_POSIT_ES, NORMAL);

    typedef struct packed {
        logic                          sign;
        logic                          zero;
        logic                          nar;
        logic signed [DEF_SCALE_W-1:0] scale;
        logic [DEF_FRAC_W-1:0]         fraction;
        logic                          guard;
        logic                          round;
        logic                          sticky;
    } pd_t;

endpackage

// File: rtl/posit_normalize_arbiter_normalizer.sv
// Combinational posit normalize/round: builds regime, exponent and fraction, rounds, negates.
// Assumes ES >= 1; scales outside the representable range saturate to maxpos/minpos.
module posit_normalizer
    import posit_normalize_arbiter_pkg::*;
#(
    parameter int        N             = 32,
    parameter int        ES            = 2,
    parameter int        SW            = 8,
    parameter int        FW            = 27,
    parameter rounding_e ROUNDING_MODE = RNTE,
    localparam int       PDW           = 6 + SW + FW
) (
    input  logic [PDW-1:0] i_pd,
    output logic [N-1:0]   o_posit
);

    localparam int TW = ES + FW + 3;
    localparam int VW = 2 + TW + N;
    localparam logic signed [SW-1:0] K_HI = SW'(N - 2);
    localparam logic signed [SW-1:0] K_LO = -K_HI;

    logic                 w_sign;
    logic                 w_zero;
    logic                 w_nar;
    logic signed [SW-1:0] w_scale;
    logic [FW-1:0]        w_frac;
    logic [2:0]           w_grs;
    logic signed [SW-1:0] w_k;
    logic [SW-1:0]        w_shamt;
    logic [VW-1:0]        w_init;
    logic [VW-1:0]        w_shifted;
    logic [N-2:0]         w_body;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_inc;
    logic [N-1:0]         w_sum;
    logic [N-2:0]         w_mag;
    logic [N-1:0]         w_pos;

    assign {w_sign, w_zero, w_nar, w_scale, w_frac, w_grs} = i_pd;

    // Regime run length is k+1 ones for k>=0 and -k zeros for k<0; an arithmetic
    // shift of a two-bit seed by k (or ~k) produces either run with its terminator.
    assign w_k       = w_scale >>> ES;
    assign w_shamt   = w_k ^ {SW{w_k[SW-1]}};
    assign w_init    = {~w_k[SW-1], w_k[SW-1], w_scale[ES-1:0], w_frac, w_grs, {N{1'b0}}};
    assign w_shifted = $signed(w_init) >>> w_shamt;

    assign w_body   = w_shifted[VW-1 -: N-1];
    assign w_guard  = w_shifted[VW-N];
    assign w_sticky = |w_shifted[VW-N-1:0];

    always_comb begin
        w_inc = 1'b0;
        case (ROUNDING_MODE)
            RZERO:    w_inc = 1'b0;
            RNTE:     w_inc = w_guard & (w_body[0] | w_sticky);
            RPLUSINF: w_inc = (w_guard | w_sticky) & ~w_sign;
            RMININF:  w_inc = (w_guard | w_sticky) & w_sign;
            default:  w_inc = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_body} + {{(N-1){1'b0}}, w_inc};

    always_comb begin
        w_mag = w_sum[N-1] ? {(N-1){1'b1}} : w_sum[N-2:0];
        if (w_k > K_HI) begin
            w_mag = {(N-1){1'b1}};
        end else if (w_k < K_LO) begin
            w_mag = {{(N-2){1'b0}}, 1'b1};
        end
    end

    assign w_pos = {1'b0, w_mag};

    always_comb begin
        o_posit = w_sign ? (~w_pos + 1'b1) : w_pos;
        if (w_nar) begin
            o_posit = {1'b1, {(N-1){1'b0}}};
        end else if (w_zero) begin
            o_posit = '0;
        end
    end

endmodule

// File: rtl/posit_normalize_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
// The pointer moves past the granted requester only when the grant is taken.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_grant_idx
);

    logic [IW-1:0] r_ptr;
    logic          w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!w_found && i_req[(int'(r_ptr) + off) % NUM_REQ]) begin
                w_found                                  = 1'b1;
                o_grant[(int'(r_ptr) + off) % NUM_REQ]   = 1'b1;
                o_grant_idx                              = IW'((int'(r_ptr) + off) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grant_idx == IW'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/posit_normalize_arbiter.sv
// Shares one posit normalizer among NUM_REQ requesters through a round-robin arbiter
// and a 2-stage valid/ready pipeline (stage 1: pd operand, stage 2: rounded posit).
module posit_normalize_arbiter
    import posit_normalize_arbiter_pkg::*;
#(
    parameter int        POSIT_WIDTH   = 32,
    parameter int        POSIT_ES      = 2,
    parameter pd_type_e  PD_TYPE       = NORMAL,
    parameter rounding_e ROUNDING_MODE = RNTE,
    parameter int        NUM_REQ       = 4,
    parameter int        ID_WIDTH      = $clog2(NUM_REQ),
    localparam int       PD_WIDTH      = pd_width(POSIT_WIDTH, POSIT_ES, PD_TYPE)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0][PD_WIDTH-1:0]  req_pd_i,
    output logic                              res_valid_o,
    input  logic                              res_ready_i,
    output logic [POSIT_WIDTH-1:0]            res_posit_o,
    output logic [ID_WIDTH-1:0]               res_id_o,
    output logic                              busy_o
);

    localparam int SCALE_W = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
    localparam int FRAC_W  = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);

    logic                   r_ready_en;
    logic                   r_s1_valid;
    logic [PD_WIDTH-1:0]    r_s1_pd;
    logic [ID_WIDTH-1:0]    r_s1_id;
    logic                   r_s2_valid;
    logic [POSIT_WIDTH-1:0] r_s2_posit;
    logic [ID_WIDTH-1:0]    r_s2_id;

    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_WIDTH-1:0]    w_grant_idx;
    logic                   w_s1_load;
    logic                   w_s2_load;
    logic                   w_take;
    logic                   w_accept;
    logic [POSIT_WIDTH-1:0] w_norm_posit;

    assign w_s2_load = !r_s2_valid | res_ready_i;
    assign w_s1_load = !r_s1_valid | w_s2_load;
    // Readies stay low for the first edge after reset release.
    assign w_take    = w_s1_load & r_ready_en;
    assign w_accept  = (|w_grant) & w_take;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_o[gi] = w_grant[gi] & w_take;
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (req_valid_i),
        .i_advance   (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    posit_normalizer #(
        .N             (POSIT_WIDTH),
        .ES            (POSIT_ES),
        .SW            (SCALE_W),
        .FW            (FRAC_W),
        .ROUNDING_MODE (ROUNDING_MODE)
    ) u_norm (
        .i_pd    (r_s1_pd),
        .o_posit (w_norm_posit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_pd    <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_posit <= '0;
            r_s2_id    <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_s1_load) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_pd <= req_pd_i[w_grant_idx];
                    r_s1_id <= w_grant_idx;
                end
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_posit <= w_norm_posit;
                    r_s2_id    <= r_s1_id;
                end
            end
        end
    end

    assign res_valid_o = r_s2_valid;
    assign res_posit_o = r_s2_posit;
    assign res_id_o    = r_s2_id;
    assign busy_o      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_posit_normalize_arbiter.sv
// Directed bench for posit_normalize_arbiter: a driver/monitor process feeds requesters and
// pops an expected-result queue that the stimulus process fills with hand-computed posits.
module tb_posit_normalize_arbiter;
    import posit_normalize_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int PDW  = $bits(pd_t);

    typedef struct {
        logic [31:0] posit;
        logic [1:0]  id;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NREQ-1:0]            req_valid_i;
    logic [NREQ-1:0]            req_ready_o;
    logic [NREQ-1:0][PDW-1:0]   req_pd_i;
    logic                       res_valid_o;
    logic                       res_ready_i;
    logic [31:0]                res_posit_o;
    logic [1:0]                 res_id_o;
    logic                       busy_o;

    exp_t           sb[$];
    int             rem[NREQ] = '{default: 0};
    logic [PDW-1:0] op[NREQ]  = '{default: '0};
    int             checks    = 0;
    int             errors    = 0;
    int             acc_count = 0;

    posit_normalize_arbiter #(
        .POSIT_WIDTH   (32),
        .POSIT_ES      (2),
        .PD_TYPE       (NORMAL),
        .ROUNDING_MODE (RNTE),
        .NUM_REQ       (NREQ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_pd_i    (req_pd_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_posit_o (res_posit_o),
        .res_id_o    (res_id_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PDW-1:0] mk(input logic s, input logic z, input logic n,
                                          input int sc, input logic [DEF_FRAC_W-1:0] fr,
                                          input logic [2:0] grs);
        pd_t p;
        p.sign     = s;
        p.zero     = z;
        p.nar      = n;
        p.scale    = DEF_SCALE_W'(sc);
        p.fraction = fr;
        p.guard    = grs[2];
        p.round    = grs[1];
        p.sticky   = grs[0];
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] p, input logic [1:0] id);
        exp_t e;
        e.posit = p;
        e.id    = id;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy_o) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || busy_o) begin
            errors++;
            $display("FAIL %s_drain: %0d results pending, required 0", name, sb.size());
        end
        repeat (2) tick();
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Driver + monitor: sample just before each rising edge, update requesters just after it.
    initial begin
        logic [NREQ-1:0] acc;
        exp_t            e;
        req_valid_i = '0;
        req_pd_i    = '0;
        forever begin
            @(negedge clk);
            #4;
            acc = req_valid_i & req_ready_o;
            check("ready_onehot", 32'($countones(req_ready_o) <= 1), 32'd1);
            if (res_valid_o && res_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id=%0d posit=%h, required no output",
                             res_id_o, res_posit_o);
                end else begin
                    e = sb.pop_front();
                    $display("result id=%0d posit=%h (expected id=%0d posit=%h)",
                             res_id_o, res_posit_o, e.id, e.posit);
                    check("res_posit", res_posit_o, e.posit);
                    check("res_id", 32'(res_id_o), 32'(e.id));
                end
            end
            acc_count += $countones(acc);
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && rem[i] > 0) rem[i]--;
                req_valid_i[i] = (rem[i] > 0);
                req_pd_i[i]    = op[i];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] held;
        res_ready_i = 1'b1;

        // Reset state and single request from requester 2.
        op[2]  = mk(1'b0, 1'b0, 1'b0, 0, '0, 3'b000);
        rem[2] = 1;
        push(32'h4000_0000, 2'd2);
        tick();
        check("rst_req_ready", 32'(req_ready_o), 32'h0);
        check("rst_res_valid", 32'(res_valid_o), 32'h0);
        check("rst_res_posit", res_posit_o, 32'h0);
        check("rst_res_id", 32'(res_id_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("release_ready_low", 32'(req_ready_o), 32'h0);
        n = 0;
        while (acc_count == 0 && n < 10) begin tick(); n++; end
        check("t1_accept", 32'(acc_count), 32'd1);
        check("t1_valid_cycle1", 32'(res_valid_o), 32'h0);
        check("t1_busy_cycle1", 32'(busy_o), 32'h1);
        tick();
        check("t1_valid_cycle2", 32'(res_valid_o), 32'h1);
        drain("t1");

        // Four simultaneous requests after reset: pointer order, back-to-back results.
        do_reset();
        op[0] = mk(1'b0, 1'b0, 1'b0, 0, '0, 3'b000);
        op[1] = mk(1'b0, 1'b0, 1'b0, 1, '0, 3'b000);
        op[2] = mk(1'b0, 1'b0, 1'b0, 4, '0, 3'b000);
        op[3] = mk(1'b0, 1'b0, 1'b1, 0, '0, 3'b000);
        push(32'h4000_0000, 2'd0);
        push(32'h4800_0000, 2'd1);
        push(32'h6000_0000, 2'd2);
        push(32'h8000_0000, 2'd3);
        for (int i = 0; i < NREQ; i++) rem[i] = 1;
        n = 0;
        while (!res_valid_o && n < 10) begin tick(); n++; end
        check("t2_first_valid", 32'(res_valid_o), 32'h1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("t2_back_to_back", 32'(res_valid_o), 32'h1);
        end
        drain("t2");

        // Fairness: requesters 0 and 3 continuously valid, 8 accepts alternate 0,3,...
        op[0] = mk(1'b0, 1'b0, 1'b0, 2, '0, 3'b000);
        op[3] = mk(1'b0, 1'b0, 1'b0, -1, '0, 3'b000);
        for (int k = 0; k < 4; k++) begin
            push(32'h5000_0000, 2'd0);
            push(32'h3800_0000, 2'd3);
        end
        acc_count = 0;
        rem[0] = 4;
        rem[3] = 4;
        drain("t3");
        check("t3_accepts", 32'(acc_count), 32'd8);

        // Backpressure: stalled output, exactly two accepts, stable held result.
        res_ready_i = 1'b0;
        op[0] = mk(1'b0, 1'b0, 1'b0, 8, '0, 3'b000);
        op[1] = mk(1'b0, 1'b0, 1'b0, -4, '0, 3'b000);
        op[2] = mk(1'b1, 1'b0, 1'b0, 0, '0, 3'b000);
        op[3] = mk(1'b0, 1'b1, 1'b0, 0, '0, 3'b000);
        push(32'h7000_0000, 2'd0);
        push(32'h2000_0000, 2'd1);
        push(32'hC000_0000, 2'd2);
        push(32'h0000_0000, 2'd3);
        acc_count = 0;
        for (int i = 0; i < NREQ; i++) rem[i] = 1;
        repeat (10) tick();
        check("t4_accepts", 32'(acc_count), 32'd2);
        check("t4_ready_low", 32'(req_ready_o), 32'h0);
        check("t4_held_valid", 32'(res_valid_o), 32'h1);
        check("t4_held_posit", res_posit_o, 32'h7000_0000);
        check("t4_held_id", 32'(res_id_o), 32'h0);
        held = res_posit_o;
        repeat (3) tick();
        check("t4_stable_posit", res_posit_o, held);
        check("t4_stable_accepts", 32'(acc_count), 32'd2);
        res_ready_i = 1'b1;
        drain("t4");

        // Rounding and saturation vectors.
        op[0] = mk(1'b0, 1'b0, 1'b0, 0, '1, 3'b100);
        op[1] = mk(1'b0, 1'b0, 1'b0, 0, 27'd1, 3'b100);
        op[2] = mk(1'b0, 1'b0, 1'b0, 0, '0, 3'b100);
        op[3] = mk(1'b0, 1'b0, 1'b0, 124, '0, 3'b000);
        push(32'h4800_0000, 2'd0);
        push(32'h4000_0002, 2'd1);
        push(32'h4000_0000, 2'd2);
        push(32'h7FFF_FFFF, 2'd3);
        for (int i = 0; i < NREQ; i++) rem[i] = 1;
        drain("t5");

        // Async reset with both stages full: flush, then requester 0 wins first.
        res_ready_i = 1'b0;
        op[1] = mk(1'b0, 1'b0, 1'b0, 4, '0, 3'b000);
        op[2] = mk(1'b0, 1'b0, 1'b0, 8, '0, 3'b000);
        rem[1] = 3;
        rem[2] = 3;
        n = 0;
        while (!(res_valid_o && req_valid_i != '0 && req_ready_o == '0) && n < 20) begin
            tick();
            n++;
        end
        check("t6_full", 32'(res_valid_o && busy_o && req_ready_o == '0), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_res_valid", 32'(res_valid_o), 32'h0);
        check("t6_rst_res_posit", res_posit_o, 32'h0);
        check("t6_rst_res_id", 32'(res_id_o), 32'h0);
        check("t6_rst_busy", 32'(busy_o), 32'h0);
        check("t6_rst_ready", 32'(req_ready_o), 32'h0);
        op[0] = mk(1'b0, 1'b0, 1'b0, 0, '0, 3'b000);
        op[2] = mk(1'b0, 1'b0, 1'b0, 1, '0, 3'b000);
        rem[0] = 1;
        rem[1] = 0;
        rem[2] = 1;
        push(32'h4000_0000, 2'd0);
        push(32'h4800_0000, 2'd2);
        res_ready_i = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        drain("t6");

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
